// File: rtl/trail_collision_reader.sv
// Per-frame collision probe: reads the trail cell one step ahead of each bike
// through the shared frame-buffer port and raises sticky hit flags.
module trail_collision_reader #(
  parameter int         X_OFFSET   = 8,
  parameter int         ROW_WORDS  = 320,
  parameter int         PLAY_MAX   = 223,
  parameter logic [2:0] PLAY_STATE = 3'b010
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [2:0]  Game_State,
  input  logic [7:0]  Blue_X,
  input  logic [7:0]  Blue_Y,
  input  logic [7:0]  Red_X,
  input  logic [7:0]  Red_Y,
  input  logic [1:0]  Blue_dir,
  input  logic [1:0]  Red_dir,
  output logic        rd_req,
  output logic [19:0] rd_addr,
  input  logic        rd_gnt,
  input  logic        rd_valid,
  input  logic [15:0] rd_data,
  output logic        blue_hit,
  output logic        red_hit,
  output logic        hit_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_CALC, S_REQ, S_WAIT, S_EVAL
  } state_t;

  state_t      state_q, state_d;
  logic        frame_q, frame_q2;
  logic [7:0]  bx_q, by_q, rx_q, ry_q, bx_d, by_d, rx_d, ry_d;
  logic [1:0]  bdir_q, rdir_q, bdir_d, rdir_d;
  logic        player_q, player_d;
  logic [1:0]  word_q, word_d;
  logic [19:0] base_q, base_d;
  logic        acc_b_q, acc_r_q, acc_b_d, acc_r_d;
  logic        blue_hit_q, red_hit_q, blue_hit_d, red_hit_d;

  logic        start, play;
  logic [7:0]  cur_x, cur_y;
  logic [1:0]  cur_dir;
  int          px, py;
  logic        wall;
  logic [19:0] base_calc, word_addr;
  logic        set_acc, adv;

  assign start = frame_q & ~frame_q2;
  assign play  = (Game_State == PLAY_STATE);

  // Probe cell of the player currently being evaluated
  always_comb begin
    cur_x   = player_q ? rx_q   : bx_q;
    cur_y   = player_q ? ry_q   : by_q;
    cur_dir = player_q ? rdir_q : bdir_q;
    px      = int'(cur_x);
    py      = int'(cur_y);
    case (cur_dir)
      2'b00:   py = py + 1;
      2'b01:   py = py - 1;
      2'b10:   px = px + 1;
      default: px = px - 1;
    endcase
    wall      = (px < 0) || (px > PLAY_MAX) || (py < 0) || (py > PLAY_MAX);
    base_calc = 20'((px + X_OFFSET) * 2 + py * ROW_WORDS * 4);
  end

  // Word order matches the writer: base, base+ROW, base+1, base+ROW+1
  assign word_addr = base_q + (word_q[0] ? 20'(ROW_WORDS) : 20'd0) + 20'(word_q[1]);

  always_comb begin
    state_d    = state_q;
    bx_d       = bx_q;
    by_d       = by_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    bdir_d     = bdir_q;
    rdir_d     = rdir_q;
    player_d   = player_q;
    word_d     = word_q;
    base_d     = base_q;
    acc_b_d    = acc_b_q;
    acc_r_d    = acc_r_q;
    blue_hit_d = blue_hit_q;
    red_hit_d  = red_hit_q;
    set_acc    = 1'b0;
    adv        = 1'b0;
    case (state_q)
      S_IDLE: if (start && play) state_d = S_LATCH;
      S_LATCH: begin
        bx_d     = Blue_X;
        by_d     = Blue_Y;
        rx_d     = Red_X;
        ry_d     = Red_Y;
        bdir_d   = Blue_dir;
        rdir_d   = Red_dir;
        player_d = 1'b0;
        acc_b_d  = 1'b0;
        acc_r_d  = 1'b0;
        state_d  = S_CALC;
      end
      S_CALC: begin
        if (wall) begin
          set_acc = 1'b1;
          adv     = 1'b1;
        end else begin
          base_d  = base_calc;
          word_d  = 2'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: if (rd_gnt) state_d = S_WAIT;
      S_WAIT: begin
        if (rd_valid) begin
          if (rd_data != 16'd0) begin
            set_acc = 1'b1;
            adv     = 1'b1;
          end else if (word_q == 2'd3) begin
            adv = 1'b1;
          end else begin
            word_d  = word_q + 2'd1;
            state_d = S_REQ;
          end
        end
      end
      S_EVAL: begin
        blue_hit_d = blue_hit_q | acc_b_q;
        red_hit_d  = red_hit_q  | acc_r_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (set_acc) begin
      if (player_q) acc_r_d = 1'b1;
      else          acc_b_d = 1'b1;
    end
    if (adv) begin
      if (!player_q) begin
        player_d = 1'b1;
        state_d  = S_CALC;
      end else begin
        state_d  = S_EVAL;
      end
    end
    // Leaving play aborts any scan and drops the round's sticky flags
    if (!play) begin
      state_d    = S_IDLE;
      blue_hit_d = 1'b0;
      red_hit_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      frame_q    <= 1'b0;
      frame_q2   <= 1'b0;
      bx_q       <= '0;
      by_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      bdir_q     <= '0;
      rdir_q     <= '0;
      player_q   <= 1'b0;
      word_q     <= '0;
      base_q     <= '0;
      acc_b_q    <= 1'b0;
      acc_r_q    <= 1'b0;
      blue_hit_q <= 1'b0;
      red_hit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_clk;
      frame_q2   <= frame_q;
      bx_q       <= bx_d;
      by_q       <= by_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      bdir_q     <= bdir_d;
      rdir_q     <= rdir_d;
      player_q   <= player_d;
      word_q     <= word_d;
      base_q     <= base_d;
      acc_b_q    <= acc_b_d;
      acc_r_q    <= acc_r_d;
      blue_hit_q <= blue_hit_d;
      red_hit_q  <= red_hit_d;
    end
  end

  assign rd_req    = (state_q == S_REQ);
  assign rd_addr   = rd_req ? word_addr : 20'd0;
  assign hit_valid = (state_q == S_EVAL) && play;
  assign busy      = (state_q != S_IDLE);
  assign blue_hit  = blue_hit_q;
  assign red_hit   = red_hit_q;

endmodule

// File: tb/tb_trail_collision_reader.sv
// Directed bench for trail_collision_reader with a simple frame-buffer responder.
module tb_trail_collision_reader;
  localparam logic [2:0] PLAY = 3'b010;

  logic        Clk = 1'b0;
  logic        Reset_n, frame_clk;
  logic [2:0]  Game_State;
  logic [7:0]  Blue_X, Blue_Y, Red_X, Red_Y;
  logic [1:0]  Blue_dir, Red_dir;
  logic        rd_req, rd_gnt, rd_valid;
  logic [19:0] rd_addr;
  logic [15:0] rd_data;
  logic        blue_hit, red_hit, hit_valid, busy;

  int checks = 0, failures = 0, hv_cnt = 0;
  logic [15:0] mem [int];
  int addr_log[$];
  bit gnt_en = 1'b1, hold_valid = 1'b0, pend = 1'b0;
  int pend_addr = 0;

  trail_collision_reader dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Game_State(Game_State),
    .Blue_X(Blue_X), .Blue_Y(Blue_Y), .Red_X(Red_X), .Red_Y(Red_Y),
    .Blue_dir(Blue_dir), .Red_dir(Red_dir),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_data(rd_data), .blue_hit(blue_hit), .red_hit(red_hit),
    .hit_valid(hit_valid), .busy(busy)
  );

  always #5 Clk = ~Clk;

  // Frame-buffer responder: grant on request, data one cycle after grant
  initial begin
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = 16'd0;
    forever begin
      @(negedge Clk);
      rd_valid = 1'b0;
      rd_data  = 16'd0;
      if (Reset_n !== 1'b1) pend = 1'b0;
      if (pend && !hold_valid) begin
        rd_valid = 1'b1;
        rd_data  = mem.exists(pend_addr) ? mem[pend_addr] : 16'd0;
        pend     = 1'b0;
      end
      rd_gnt = (rd_req === 1'b1) && gnt_en && !pend;
      if (rd_gnt) begin
        pend      = 1'b1;
        pend_addr = int'(rd_addr);
        addr_log.push_back(int'(rd_addr));
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    if (hit_valid === 1'b1) hv_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_bikes(input logic [7:0] bx, by, input logic [1:0] bd,
                           input logic [7:0] rx, ry, input logic [1:0] rdr);
    Blue_X = bx; Blue_Y = by; Blue_dir = bd;
    Red_X  = rx; Red_Y  = ry; Red_dir  = rdr;
  endtask

  task automatic frame_pulse();
    @(posedge Clk); #1 frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 frame_clk = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge Clk);
      if (hit_valid === 1'b1) ok = 1'b1;
    end
    @(posedge Clk); #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk);
      if (rd_req === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_req"},    rd_req,    1'b0);
    chk({tag, "_rd_addr"},   rd_addr,   20'd0);
    chk({tag, "_blue_hit"},  blue_hit,  1'b0);
    chk({tag, "_red_hit"},   red_hit,   1'b0);
    chk({tag, "_hit_valid"}, hit_valid, 1'b0);
    chk({tag, "_busy"},      busy,      1'b0);
  endtask

  initial begin
    bit ok, stable;
    int hv0;
    Reset_n = 1'b0; frame_clk = 1'b0; Game_State = 3'b000;
    set_bikes(8'd0, 8'd0, 2'b00, 8'd0, 8'd0, 2'b00);
    repeat (3) @(posedge Clk);
    #1 chk_all_zero("reset");
    Reset_n = 1'b1; Game_State = PLAY;
    @(posedge Clk); #1;

    // 1: empty buffer, full 8-read scan
    set_bikes(8'd10, 8'd10, 2'b10, 8'd50, 8'd50, 2'b00);
    addr_log.delete(); hv0 = hv_cnt;
    frame_pulse(); wait_done(ok);
    chk("t1_done", ok, 1'b1);
    chk("t1_nreads", addr_log.size(), 8);
    chk("t1_addr0", addr_log[0], 12838);
    chk("t1_addr1", addr_log[1], 13158);
    chk("t1_addr2", addr_log[2], 12839);
    chk("t1_addr3", addr_log[3], 13159);
    chk("t1_addr4", addr_log[4], 65396);
    chk("t1_addr7", addr_log[7], 65717);
    chk("t1_blue", blue_hit, 1'b0);
    chk("t1_red", red_hit, 1'b0);
    chk("t1_busy_after", busy, 1'b0);
    chk("t1_hv_pulses", hv_cnt - hv0, 1);

    // 2: trail at base+ROW ends blue reads early
    mem[13158] = 16'h0005;
    addr_log.delete();
    frame_pulse(); wait_done(ok);
    chk("t2_done", ok, 1'b1);
    chk("t2_nreads", addr_log.size(), 6);
    chk("t2_addr1", addr_log[1], 13158);
    chk("t2_addr2", addr_log[2], 65396);
    chk("t2_blue", blue_hit, 1'b1);
    chk("t2_red", red_hit, 1'b0);

    // leaving play clears sticky flags
    Game_State = 3'b000;
    repeat (2) @(posedge Clk);
    #1 chk("clr_blue", blue_hit, 1'b0);
    Game_State = PLAY;

    // 3: both probes off the playfield
    set_bikes(8'd0, 8'd5, 2'b11, 8'd223, 8'd7, 2'b10);
    addr_log.delete();
    frame_pulse(); wait_done(ok);
    chk("t3_done", ok, 1'b1);
    chk("t3_nreads", addr_log.size(), 0);
    chk("t3_blue", blue_hit, 1'b1);
    chk("t3_red", red_hit, 1'b1);

    // 5: abort mid-WAIT, late data ignored
    mem.delete(); mem[12838] = 16'h0007;
    set_bikes(8'd10, 8'd10, 2'b10, 8'd50, 8'd50, 2'b00);
    hold_valid = 1'b1; addr_log.delete(); hv0 = hv_cnt;
    frame_pulse();
    for (int i = 0; i < 50 && addr_log.size() == 0; i++) @(posedge Clk);
    repeat (2) @(posedge Clk);
    #1 chk("t5_in_wait", busy, 1'b1);
    Game_State = 3'b011;
    @(posedge Clk); #1;
    chk("t5_rd_req", rd_req, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_blue", blue_hit, 1'b0);
    chk("t5_red", red_hit, 1'b0);
    Game_State = PLAY; hold_valid = 1'b0;
    repeat (6) @(posedge Clk);
    #1 chk("t5_no_hv", hv_cnt - hv0, 0);
    chk("t5_late_blue", blue_hit, 1'b0);
    chk("t5_nreads", addr_log.size(), 1);

    // 4: grant withheld for 20 cycles
    mem.delete(); gnt_en = 1'b0; addr_log.delete();
    frame_pulse(); wait_req(ok);
    chk("t4_req_seen", ok, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (rd_req !== 1'b1 || rd_addr !== 20'd12838) stable = 1'b0;
    end
    chk("t4_stable", stable, 1'b1);
    gnt_en = 1'b1;
    wait_done(ok);
    chk("t4_done", ok, 1'b1);
    chk("t4_nreads", addr_log.size(), 8);
    chk("t4_addr0", addr_log[0], 12838);
    chk("t4_blue", blue_hit, 1'b0);
    chk("t4_red", red_hit, 1'b0);

    // 6: async reset mid-REQ
    gnt_en = 1'b0;
    frame_pulse(); wait_req(ok);
    chk("t6_req_seen", ok, 1'b1);
    #2 Reset_n = 1'b0;
    #1 chk_all_zero("t6_rst");
    @(posedge Clk); #1 Reset_n = 1'b1; gnt_en = 1'b1;
    @(posedge Clk); #1;

    // 6b: second frame edge while busy is ignored
    addr_log.delete(); hv0 = hv_cnt;
    frame_pulse();
    repeat (2) @(posedge Clk);
    #1 chk("t6_busy", busy, 1'b1);
    frame_pulse();
    repeat (60) @(posedge Clk);
    #1 chk("t6_hv_pulses", hv_cnt - hv0, 1);
    chk("t6_nreads", addr_log.size(), 8);
    chk("t6_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
